data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Shares the single-port Data_Memory between two requesters: port 0 (CPU MEM stage) and port 1 (DMA/debug loader). Registers one command per transaction, drives the memory strobes for exactly one cycle, captures the registered read data and returns it with a one-cycle Ack pulse. CPU has priority, with a streak limit so port 1 cannot starve. Sits between the requesters and Data_Memory, which executes on the negedge and registers ReadData.

Parameters:
DATA_W, 32, data and address width
MEM_DEPTH, 32, number of valid words; word address must be < MEM_DEPTH
CPU_STREAK, 4, maximum consecutive port-0 grants while port 1 is pending

Ports:
Clk  in  1  clock; FSM updates on posedge
Reset_n  in  1  asynchronous, active-low reset
Req0, Req1  in  1  request; held high with Addr/WData/We stable until Ack
Addr0, Addr1  in  DATA_W  word address
WData0, WData1  in  DATA_W  write data
We0, We1  in  1  1 = write, 0 = read
Ack0, Ack1  out  1  one-cycle completion pulse
RData0, RData1  out  DATA_W  read data; valid while Ack high, held afterwards
Err0, Err1  out  1  address out of range; valid with Ack
Mem_Address  out  DATA_W  to Data_Memory Address
Mem_WriteData  out  DATA_W  to Data_Memory WriteData
Mem_MemRead, Mem_MemWrite  out  1  to Data_Memory strobes
Mem_ReadData  in  DATA_W  from Data_Memory ReadData
Busy  out  1  high in ISSUE and RESP

Behaviour:
- Reset (async, Reset_n=0): state IDLE; all outputs 0; streak counter 0; last-grant = port 1. Strobes drop immediately, combinationally with reset.
- States: IDLE, ISSUE, RESP.
- IDLE: at a posedge with any Req high, select a winner and latch its Addr/WData/We and id; go to ISSUE. No Req: stay.
- Arbitration: only Req0 -> port 0; only Req1 -> port 1; both -> port 0 unless streak == CPU_STREAK, then port 1.
- Streak counter: +1 on a port-0 grant while Req1 is high (saturates at CPU_STREAK); cleared on any port-1 grant or when Req1 is low at grant.
- ISSUE (exactly 1 cycle): Mem_Address/Mem_WriteData come from latched values. Mem_MemWrite = We, Mem_MemRead = !We. Both strobes are 0 if the address >= MEM_DEPTH. Memory acts on the negedge inside this cycle. At the next posedge, latch Mem_ReadData into RData<id> on reads only (RData of the other port unchanged) and set Err<id>. Go to RESP.
- RESP (exactly 1 cycle): Ack<id>=1, Err<id> valid. Go to IDLE unconditionally; the requester drops Req at that posedge.
- Latency: Req sampled at posedge t, strobes in cycle t+1, Ack in cycle t+2. Throughput is 1 transaction per 3 cycles. A Req that rises during ISSUE/RESP waits for IDLE.
- Out-of-range: no strobe; RData unchanged; Err=1 with Ack. The streak counter still updates.
- Never both Mem_MemRead and Mem_MemWrite high. Never both Acks high.
- Reset mid-ISSUE: if asserted before the negedge, no memory write occurs; if after, the write has completed. No Ack is issued in either case, and the requester must reissue.
- Req dropped before Ack is a protocol violation; the transaction still completes and Ack still pulses.

Decomposition:
- Shared package (mips_mem_pkg): DATA_W, MEM_DEPTH, state encoding constants (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), port id constants.
- One natural sub-module: mem_arb_pick, a combinational winner select plus streak counter register, with inputs Req0, Req1 and the grant event.
- Testbench instantiates data_mem_arbiter with Data_Memory as the real memory model.

Test Plan:
- Reset, then Req0 read Addr0=7 -> strobe MemRead in cycle t+1, Ack0 in t+2 with RData0=666, Err0=0; Ack1 never high.
- Req1 write Addr1=3, WData1=0x1234, then Req0 read Addr0=3 -> RData0=0x1234; Mem_MemWrite high exactly 1 cycle.
- Req0 and Req1 rise together (reads of 7 and 9) -> Ack0 (666) first, then Ack1 (555) 3 cycles later.
- Req0 and Req1 held continuously, CPU_STREAK=4 -> grant order 0,0,0,0,1,0,0,0,0,1; port 1 served every 5th transaction.
- Req0 read Addr0=40 -> no strobe, Ack0 with Err0=1, RData0 holds its previous value.
- Reset_n pulsed low mid-ISSUE on a write to address 5, before the negedge -> all outputs 0 at once, MemData[5] unchanged, no Ack; after release the arbiter is IDLE and serves the next Req normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory arbiter: widths, depth, CPU streak
// limit, FSM state encoding and requester port ids.
package mips_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int MEM_DEPTH  = 32;
  localparam int CPU_STREAK = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arbState_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between CPU (port 0) and DMA (port 1), with a streak counter
// that forces a DMA grant after CPU_STREAK back-to-back CPU wins.
module mem_arb_pick #(
  parameter int CPU_STREAK = mips_mem_pkg::CPU_STREAK
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Req0,
  input  logic Req1,
  input  logic grant,
  output logic winner
);
  import mips_mem_pkg::*;

  localparam int STREAK_W = $clog2(CPU_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CPU_STREAK);

  logic [STREAK_W-1:0] streak;

  always_comb begin
    winner = PORT_CPU;
    if (Req0 && Req1) begin
      winner = (streak == STREAK_MAX) ? PORT_DMA : PORT_CPU;
    end else if (Req1) begin
      winner = PORT_DMA;
    end
  end

  // Only CPU wins while the DMA is actually waiting count toward starvation.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      streak <= '0;
    end else if (grant) begin
      if (winner == PORT_DMA || !Req1) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port front end for the single-port Data_Memory: latches one command,
// strobes the memory for one cycle, then returns data with a one-cycle Ack.
module data_mem_arbiter #(
  parameter int DATA_W     = mips_mem_pkg::DATA_W,
  parameter int MEM_DEPTH  = mips_mem_pkg::MEM_DEPTH,
  parameter int CPU_STREAK = mips_mem_pkg::CPU_STREAK
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [DATA_W-1:0] Addr0,
  input  logic [DATA_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  input  logic              We0,
  input  logic              We1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic              Err0,
  output logic              Err1,
  output logic [DATA_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_WriteData,
  output logic              Mem_MemRead,
  output logic              Mem_MemWrite,
  input  logic [DATA_W-1:0] Mem_ReadData,
  output logic              Busy
);
  import mips_mem_pkg::*;

  localparam logic [DATA_W-1:0] DEPTH_LIMIT = DATA_W'(MEM_DEPTH);

  arbState_t         state;
  logic              curId;
  logic              curWe;
  logic              curOk;
  logic              grant;
  logic              winner;
  logic [DATA_W-1:0] selAddr;
  logic [DATA_W-1:0] selWData;
  logic              selWe;
  logic              selOk;

  assign grant    = (state == IDLE) && (Req0 || Req1);
  assign selAddr  = (winner == PORT_DMA) ? Addr1  : Addr0;
  assign selWData = (winner == PORT_DMA) ? WData1 : WData0;
  assign selWe    = (winner == PORT_DMA) ? We1    : We0;
  assign selOk    = selAddr < DEPTH_LIMIT;

  mem_arb_pick #(
    .CPU_STREAK(CPU_STREAK)
  ) pick (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .Req0   (Req0),
    .Req1   (Req1),
    .grant  (grant),
    .winner (winner)
  );

  // Strobes are registered so they appear for exactly the ISSUE cycle and
  // vanish the moment reset is asserted, blocking a pending negedge write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      curId         <= PORT_DMA;
      curWe         <= 1'b0;
      curOk         <= 1'b0;
      Mem_Address   <= '0;
      Mem_WriteData <= '0;
      Mem_MemRead   <= 1'b0;
      Mem_MemWrite  <= 1'b0;
      Ack0          <= 1'b0;
      Ack1          <= 1'b0;
      Err0          <= 1'b0;
      Err1          <= 1'b0;
      RData0        <= '0;
      RData1        <= '0;
      Busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            curId         <= winner;
            curWe         <= selWe;
            curOk         <= selOk;
            Mem_Address   <= selAddr;
            Mem_WriteData <= selWData;
            Mem_MemWrite  <= selWe && selOk;
            Mem_MemRead   <= !selWe && selOk;
            Busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          Mem_MemRead  <= 1'b0;
          Mem_MemWrite <= 1'b0;
          if (curId == PORT_DMA) begin
            Ack1 <= 1'b1;
            Err1 <= !curOk;
            if (!curWe && curOk) RData1 <= Mem_ReadData;
          end else begin
            Ack0 <= 1'b1;
            Err0 <= !curOk;
            if (!curWe && curOk) RData0 <= Mem_ReadData;
          end
          state <= RESP;
        end
        RESP: begin
          Ack0  <= 1'b0;
          Ack1  <= 1'b0;
          Err0  <= 1'b0;
          Err1  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Mem_MemRead  <= 1'b0;
          Mem_MemWrite <= 1'b0;
          Busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of the memory and the CPU-priority rule.
module tb_data_mem_arbiter;

  localparam int DW     = 32;
  localparam int DEPTH  = 32;
  localparam int STREAK = 4;

  logic          Clk, Reset_n;
  logic          Req0, Req1, We0, We1;
  logic [DW-1:0] Addr0, Addr1, WData0, WData1;
  logic          Ack0, Ack1, Err0, Err1, Busy;
  logic [DW-1:0] RData0, RData1;
  logic [DW-1:0] Mem_Address, Mem_WriteData, Mem_ReadData;
  logic          Mem_MemRead, Mem_MemWrite;

  logic [DW-1:0] memData [0:DEPTH-1];
  logic [DW-1:0] memReadData;

  int vectors = 0;
  int miscompares = 0;
  int ackSeen0 = 0, ackSeen1 = 0, bothAck = 0, bothStrobe = 0, writeCycles = 0;

  logic [DW-1:0] refMem [0:DEPTH-1];
  logic [DW-1:0] refRData [0:1];
  logic          pend [0:1];
  logic          cmdWe [0:1];
  logic [DW-1:0] cmdAddr [0:1];
  logic [DW-1:0] cmdWData [0:1];
  int            cpuRun;

  assign Mem_ReadData = memReadData;

  data_mem_arbiter dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Req0         (Req0),
    .Req1         (Req1),
    .Addr0        (Addr0),
    .Addr1        (Addr1),
    .WData0       (WData0),
    .WData1       (WData1),
    .We0          (We0),
    .We1          (We1),
    .Ack0         (Ack0),
    .Ack1         (Ack1),
    .RData0       (RData0),
    .RData1       (RData1),
    .Err0         (Err0),
    .Err1         (Err1),
    .Mem_Address  (Mem_Address),
    .Mem_WriteData(Mem_WriteData),
    .Mem_MemRead  (Mem_MemRead),
    .Mem_MemWrite (Mem_MemWrite),
    .Mem_ReadData (Mem_ReadData),
    .Busy         (Busy)
  );

  function automatic logic [DW-1:0] initWord(input int i);
    if (i == 7) return 32'd666;
    if (i == 9) return 32'd555;
    return 32'hA500_0000 | 32'(i);
  endfunction

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Data_Memory stand-in: acts on the negedge and registers ReadData.
  initial begin
    for (int i = 0; i < DEPTH; i++) memData[i] = initWord(i);
    memReadData = '0;
    forever begin
      @(negedge Clk);
      if (Mem_MemWrite) memData[Mem_Address[4:0]] = Mem_WriteData;
      if (Mem_MemRead) memReadData = memData[Mem_Address[4:0]];
    end
  end

  always @(negedge Clk) begin
    if (Ack0) ackSeen0++;
    if (Ack1) ackSeen1++;
    if (Ack0 && Ack1) bothAck++;
    if (Mem_MemRead && Mem_MemWrite) bothStrobe++;
    if (Mem_MemWrite) writeCycles++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    Req0   = pend[0];
    Addr0  = cmdAddr[0];
    WData0 = cmdWData[0];
    We0    = cmdWe[0];
    Req1   = pend[1];
    Addr1  = cmdAddr[1];
    WData1 = cmdWData[1];
    We1    = cmdWe[1];
  endtask

  task automatic newCmd(input int p, input logic [DW-1:0] addr, input logic we, input logic [DW-1:0] wdata);
    pend[p]     = 1'b1;
    cmdAddr[p]  = addr;
    cmdWe[p]    = we;
    cmdWData[p] = wdata;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, 64'({Ack0, Ack1, Err0, Err1, Busy, Mem_MemRead, Mem_MemWrite}), 64'(0));
    checkOutput({tag, "_maddr"}, 64'(Mem_Address), 64'(0));
    checkOutput({tag, "_mwdata"}, 64'(Mem_WriteData), 64'(0));
    checkOutput({tag, "_rdata"}, 64'({RData1, RData0}), 64'(0));
  endtask

  // One full transaction starting from IDLE, predicted at transaction level.
  task automatic serveOne(input logic keep, output logic w);
    logic          ok, we;
    logic [DW-1:0] addr, wdata;
    logic [1:0]    expAck;
    w = (pend[0] && pend[1]) ? (cpuRun == STREAK) : pend[1];
    cpuRun = (!w && pend[1]) ? ((cpuRun < STREAK) ? cpuRun + 1 : STREAK) : 0;
    addr  = cmdAddr[w];
    we    = cmdWe[w];
    wdata = cmdWData[w];
    ok    = addr < DEPTH;
    tick();
    checkOutput("busyIssue", 64'(Busy), 64'(1));
    checkOutput("strobes", 64'({Mem_MemRead, Mem_MemWrite}), 64'(ok ? (we ? 2'b01 : 2'b10) : 2'b00));
    checkOutput("memAddr", 64'(Mem_Address), 64'(addr));
    if (we && ok) checkOutput("memWData", 64'(Mem_WriteData), 64'(wdata));
    if (ok) begin
      if (we) refMem[addr[4:0]] = wdata;
      else refRData[w] = refMem[addr[4:0]];
    end
    tick();
    expAck = w ? 2'b10 : 2'b01;
    checkOutput("ack", 64'({Ack1, Ack0}), 64'(expAck));
    checkOutput("err", 64'({Err1, Err0}), 64'(ok ? 2'b00 : expAck));
    checkOutput("rdata0", 64'(RData0), 64'(refRData[0]));
    checkOutput("rdata1", 64'(RData1), 64'(refRData[1]));
    checkOutput("strobesResp", 64'({Mem_MemRead, Mem_MemWrite}), 64'(0));
    if (!keep) begin
      pend[w] = 1'b0;
      applyStimulus();
    end
    tick();
    checkOutput("idle", 64'({Ack1, Ack0, Busy}), 64'(0));
  endtask

  initial begin
    logic       w;
    logic [9:0] order;
    logic [DW-1:0] prev;
    int a0, a1, wc;

    Reset_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0;
      cmdWe[p] = 1'b0;
      cmdAddr[p] = '0;
      cmdWData[p] = '0;
      refRData[p] = '0;
    end
    for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);
    cpuRun = 0;
    applyStimulus();

    #2;
    checkAllZero("reset");
    #10;
    Reset_n = 1'b1;
    tick();

    $display("[TB] single CPU read of address 7");
    newCmd(0, 32'd7, 1'b0, 32'd0);
    applyStimulus();
    a1 = ackSeen1;
    serveOne(1'b0, w);
    checkOutput("t1_rdata0", 64'(RData0), 64'(666));
    checkOutput("t1_noAck1", 64'(ackSeen1 - a1), 64'(0));

    $display("[TB] DMA write then CPU read-back");
    newCmd(1, 32'd3, 1'b1, 32'h1234);
    applyStimulus();
    wc = writeCycles;
    serveOne(1'b0, w);
    checkOutput("t2_writeCycles", 64'(writeCycles - wc), 64'(1));
    newCmd(0, 32'd3, 1'b0, 32'd0);
    applyStimulus();
    serveOne(1'b0, w);
    checkOutput("t2_rdata0", 64'(RData0), 64'(32'h1234));

    $display("[TB] simultaneous requests");
    newCmd(0, 32'd7, 1'b0, 32'd0);
    newCmd(1, 32'd9, 1'b0, 32'd0);
    applyStimulus();
    serveOne(1'b0, w);
    checkOutput("t3_firstWinner", 64'(w), 64'(0));
    checkOutput("t3_rdata0", 64'(RData0), 64'(666));
    serveOne(1'b0, w);
    checkOutput("t3_secondWinner", 64'(w), 64'(1));
    checkOutput("t3_rdata1", 64'(RData1), 64'(555));

    $display("[TB] both ports held, streak limit");
    newCmd(0, 32'd7, 1'b0, 32'd0);
    newCmd(1, 32'd9, 1'b0, 32'd0);
    applyStimulus();
    order = '0;
    for (int k = 0; k < 10; k++) begin
      serveOne(1'b1, w);
      order[k] = w;
    end
    checkOutput("t4_grantOrder", 64'(order), 64'(10'h210));
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    applyStimulus();

    $display("[TB] out-of-range CPU read");
    prev = refRData[0];
    newCmd(0, 32'd40, 1'b0, 32'd0);
    applyStimulus();
    serveOne(1'b0, w);
    checkOutput("t5_rdataHeld", 64'(RData0), 64'(prev));

    $display("[TB] reset during ISSUE of a write");
    newCmd(0, 32'd5, 1'b1, 32'hDEAD_BEEF);
    applyStimulus();
    a0 = ackSeen0;
    a1 = ackSeen1;
    tick();
    checkOutput("t6_writeStrobe", 64'(Mem_MemWrite), 64'(1));
    Reset_n = 1'b0;
    #1;
    checkAllZero("t6_reset");
    pend[0] = 1'b0;
    applyStimulus();
    #5;
    Reset_n = 1'b1;
    checkOutput("t6_mem5", 64'(memData[5]), 64'(refMem[5]));
    refRData[0] = '0;
    refRData[1] = '0;
    cpuRun = 0;
    tick();
    tick();
    checkOutput("t6_noAck", 64'(ackSeen0 + ackSeen1 - a0 - a1), 64'(0));
    newCmd(0, 32'd5, 1'b0, 32'd0);
    applyStimulus();
    serveOne(1'b0, w);
    checkOutput("t6_rdata0", 64'(RData0), 64'(initWord(5)));

    $display("[TB] random traffic");
    for (int r = 0; r < 40; r++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1))
          newCmd(p, $urandom_range(0, 39), 1'($urandom_range(0, 1)), $urandom());
      end
      if (!pend[0] && !pend[1])
        newCmd(int'($urandom_range(0, 1)), $urandom_range(0, 39), 1'($urandom_range(0, 1)), $urandom());
      applyStimulus();
      serveOne(1'b0, w);
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    applyStimulus();

    for (int i = 0; i < DEPTH; i++)
      checkOutput("memContents", 64'(memData[i]), 64'(refMem[i]));
    checkOutput("neverBothStrobes", 64'(bothStrobe), 64'(0));
    checkOutput("neverBothAcks", 64'(bothAck), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
